data_ram: RTL and testbench

DATA_RAM -- requirements
Module: data_ram

---
 rtl/async_arm_pkg.sv | 23 ++
 rtl/toggle_sync.sv | 23 ++
 rtl/data_ram.sv | 147 ++++++++++++++
 tb/tb_data_ram.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_arm_pkg.sv
// Shared types and constants for the async memory-stage blocks.
// The data RAM controller state encoding and the read/write flag values live here.
package async_arm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } ram_state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Wide enough for the 0..15 wait-cycle range.
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
  } ram_req_t;

endpackage : async_arm_pkg

// File: rtl/toggle_sync.sv
// Two-flop synchronizer for a single level/toggle signal crossing into clk.
module toggle_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb sync_d = {sync_q[0], d};

  // NOTE: flops use non-blocking (<=) so each stage samples its pre-edge input;
  // blocking assignment would let d ripple through both stages in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[1];

endmodule : toggle_sync

// File: rtl/data_ram.sv
// Word-addressed data RAM behind a two-phase (toggle) request handshake.
// Optional macro DATA_RAM_ALIGN_CHECK_EN adds errOut for misaligned/out-of-range requests.
module data_ram
  import async_arm_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        triggerIn,
  input  logic [31:0] addrIn,
  input  logic [31:0] dataIn,
  input  logic        rwIn,
  output logic [31:0] dataOut,
  output logic        readyOut
`ifdef DATA_RAM_ALIGN_CHECK_EN
  ,
  output logic        errOut
`endif
);

  localparam int               AW       = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY);

  ram_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ram_req_t         req_q, req_d;
  logic             trig_seen_q, trig_seen_d;
  logic             ready_q, ready_d;
  logic [31:0]      data_out_q, data_out_d;

  logic             trig_sync;
  logic             pending;
  logic [AW-1:0]    word_idx;
  logic             in_range;
  logic             access_ok;
  logic             mem_we;
  logic [31:0]      rd_word;
  logic [31:0]      mem [DEPTH];

  toggle_sync u_trig_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (triggerIn),
    .q     (trig_sync)
  );

  assign pending  = trig_sync ^ trig_seen_q;
  assign word_idx = req_q.addr[AW+1:2];
  assign in_range = (req_q.addr[31:AW+2] == '0);
  assign rd_word  = mem[word_idx];

`ifdef DATA_RAM_ALIGN_CHECK_EN
  logic err_q, err_d;
  assign access_ok = in_range & (req_q.addr[1:0] == 2'b00);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_q.addr[1:0];
  assign access_ok       = in_range;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    trig_seen_d = trig_seen_q;
    ready_d     = ready_q;
    data_out_d  = data_out_q;
    mem_we      = 1'b0;
`ifdef DATA_RAM_ALIGN_CHECK_EN
    err_d       = err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (pending) begin
          req_d.addr  = addrIn;
          req_d.data  = dataIn;
          req_d.rw    = rwIn;
          trig_seen_d = trig_sync;
          ready_d     = 1'b0;
          cnt_d       = LAT_LOAD;
          state_d     = (LATENCY == 0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Leave on the edge that brings the counter to 0: exactly LATENCY cycles here.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACCESS: begin
        if (req_q.rw == RW_WRITE) mem_we = access_ok;
        else                      data_out_d = in_range ? rd_word : '0;
`ifdef DATA_RAM_ALIGN_CHECK_EN
        err_d = ~access_ok;
`endif
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      trig_seen_q <= 1'b0;
      ready_q     <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      trig_seen_q <= trig_seen_d;
      ready_q     <= ready_d;
      data_out_q  <= data_out_d;
    end
  end

`ifdef DATA_RAM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign errOut = err_q;
`endif

  // NOTE: the array has no reset; contents survive reset, and reset forces IDLE
  // asynchronously so mem_we is already low for any aborted write.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx] <= req_q.data;
  end

  assign dataOut  = data_out_q;
  // A raw toggle drops ready immediately, before it reaches the synchronizer.
  assign readyOut = ready_q & ~(triggerIn ^ trig_seen_q);

endmodule : data_ram

// File: tb/tb_data_ram.sv
// Directed self-checking bench for data_ram with default DEPTH=1024, LATENCY=2.
module tb_data_ram;

  localparam int LAT      = 2;
  localparam int FULL_LAT = 4 + LAT;

  logic        clk;
  logic        reset;
  logic        trigger_in;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic        rw_in;
  logic [31:0] data_out;
  logic        ready_out;
`ifdef DATA_RAM_ALIGN_CHECK_EN
  logic        err_out;
`endif

  int n_checks;
  int n_fail;

  data_ram #(.DEPTH(1024), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .triggerIn (trigger_in),
    .addrIn    (addr_in),
    .dataIn    (data_in),
    .rwIn      (rw_in),
    .dataOut   (data_out),
    .readyOut  (ready_out)
`ifdef DATA_RAM_ALIGN_CHECK_EN
    ,
    .errOut    (err_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request on a falling edge by toggling the trigger.
  task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    addr_in    = addr;
    data_in    = data;
    rw_in      = rw;
    trigger_in = ~trigger_in;
  endtask

  task automatic flip(input logic [31:0] addr);
    @(negedge clk);
    addr_in    = addr;
    rw_in      = 1'b0;
    trigger_in = ~trigger_in;
  endtask

  // Rising edges until readyOut is seen high; -1 when the bound expires.
  task automatic wait_ready(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (ready_out === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset      = 1'b0;
    trigger_in = 1'b0;
    addr_in    = '0;
    data_in    = '0;
    rw_in      = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ready_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0", ready_out);
    end
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 00000000", data_out);
    end
    reset = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (ready_out !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_request: got %b want 0", ready_out);
    end
  endtask

  task automatic test_write_read;
    int cyc;
    issue(1'b1, 32'h10, 32'hDEADBEEF);
    wait_ready(cyc);
    n_checks++;
    if (cyc !== FULL_LAT) begin
      n_fail++; $display("FAIL write_latency: got %0d want %0d", cyc, FULL_LAT);
    end
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++; $display("FAIL write_keeps_dataout: got %h want 00000000", data_out);
    end
    issue(1'b0, 32'h10, 32'h0);
    wait_ready(cyc);
    n_checks++;
    if (cyc !== FULL_LAT) begin
      n_fail++; $display("FAIL read_latency: got %0d want %0d", cyc, FULL_LAT);
    end
    n_checks++;
    if (data_out !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL read_0x10: got %h want deadbeef", data_out);
    end
    issue(1'b0, 32'h12, 32'h0);
    wait_ready(cyc);
    n_checks++;
    if (data_out !== 32'hDEADBEEF || cyc !== FULL_LAT) begin
      n_fail++; $display("FAIL read_lsb_ignored: got %h/%0d want deadbeef/%0d", data_out, cyc, FULL_LAT);
    end
  endtask

  task automatic test_ready_comb;
    int cyc;
    @(negedge clk);
    n_checks++;
    if (ready_out !== 1'b1) begin
      n_fail++; $display("FAIL ready_before_toggle: got %b want 1", ready_out);
    end
    issue(1'b0, 32'h10, 32'h0);
    #1;
    n_checks++;
    if (ready_out !== 1'b0) begin
      n_fail++; $display("FAIL ready_drops_on_toggle: got %b want 0", ready_out);
    end
    wait_ready(cyc);
    n_checks++;
    if (cyc !== FULL_LAT) begin
      n_fail++; $display("FAIL comb_request_latency: got %0d want %0d", cyc, FULL_LAT);
    end
  endtask

  task automatic test_out_of_range;
    int cyc;
    issue(1'b1, 32'h0, 32'h01234567);
    wait_ready(cyc);
    issue(1'b1, 32'h1000, 32'hCAFEF00D);
    wait_ready(cyc);
`ifdef DATA_RAM_ALIGN_CHECK_EN
    n_checks++;
    if (err_out !== 1'b1) begin
      n_fail++; $display("FAIL oor_err: got %b want 1", err_out);
    end
`endif
    issue(1'b0, 32'h1000, 32'h0);
    wait_ready(cyc);
    n_checks++;
    if (data_out !== 32'h0 || cyc !== FULL_LAT) begin
      n_fail++; $display("FAIL oor_read_zero: got %h/%0d want 00000000/%0d", data_out, cyc, FULL_LAT);
    end
    issue(1'b0, 32'h0, 32'h0);
    wait_ready(cyc);
    n_checks++;
    if (data_out !== 32'h01234567) begin
      n_fail++; $display("FAIL oor_write_dropped: got %h want 01234567", data_out);
    end
  endtask

  task automatic test_reset_abort;
    int cyc;
    issue(1'b1, 32'h20, 32'h11112222);
    wait_ready(cyc);
    issue(1'b1, 32'h20, 32'h00000055);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset      = 1'b0;
    trigger_in = 1'b0;
    #1;
    n_checks++;
    if (ready_out !== 1'b0) begin
      n_fail++; $display("FAIL abort_ready: got %b want 0", ready_out);
    end
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++; $display("FAIL abort_data: got %h want 00000000", data_out);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    issue(1'b0, 32'h20, 32'h0);
    wait_ready(cyc);
    n_checks++;
    if (cyc !== FULL_LAT) begin
      n_fail++; $display("FAIL abort_next_latency: got %0d want %0d", cyc, FULL_LAT);
    end
    n_checks++;
    if (data_out !== 32'h11112222) begin
      n_fail++; $display("FAIL abort_no_write: got %h want 11112222", data_out);
    end
  endtask

  task automatic test_reset_pending;
    int cyc;
    @(negedge clk);
    reset      = 1'b0;
    trigger_in = 1'b1;
    addr_in    = 32'h10;
    rw_in      = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_ready(cyc);
    n_checks++;
    if (cyc !== FULL_LAT) begin
      n_fail++; $display("FAIL high_trigger_latency: got %0d want %0d", cyc, FULL_LAT);
    end
    n_checks++;
    if (data_out !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL high_trigger_read: got %h want deadbeef", data_out);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    issue(1'b1, 32'h30, 32'hAAAA0001);
    wait_ready(cyc);
    issue(1'b1, 32'h34, 32'hBBBB0002);
    wait_ready(cyc);
    issue(1'b1, 32'h38, 32'hCCCC0003);
    wait_ready(cyc);

    // Two extra toggles while busy: net parity even, no second request.
    issue(1'b0, 32'h30, 32'h0);
    repeat (3) @(posedge clk);
    flip(32'h34);
    flip(32'h34);
    wait_ready(cyc);
    n_checks++;
    if (cyc !== 2) begin
      n_fail++; $display("FAIL two_toggle_done_at: got %0d want 2", cyc);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (ready_out !== 1'b1 || data_out !== 32'hAAAA0001) begin
      n_fail++; $display("FAIL two_toggle_single: got %b/%h want 1/aaaa0001", ready_out, data_out);
    end

    // Three extra toggles: one more request, served after the first completes.
    issue(1'b0, 32'h38, 32'h0);
    repeat (3) @(posedge clk);
    flip(32'h34);
    flip(32'h34);
    flip(32'h34);
    @(negedge clk);
    n_checks++;
    if (ready_out !== 1'b0 || data_out !== 32'hCCCC0003) begin
      n_fail++; $display("FAIL three_toggle_first: got %b/%h want 0/cccc0003", ready_out, data_out);
    end
    wait_ready(cyc);
    n_checks++;
    if (cyc !== 5) begin
      n_fail++; $display("FAIL three_toggle_second_at: got %0d want 5", cyc);
    end
    n_checks++;
    if (data_out !== 32'hBBBB0002) begin
      n_fail++; $display("FAIL three_toggle_second_data: got %h want bbbb0002", data_out);
    end
  endtask

`ifdef DATA_RAM_ALIGN_CHECK_EN
  task automatic test_align_check;
    int cyc;
    issue(1'b1, 32'h13, 32'h99999999);
    wait_ready(cyc);
    n_checks++;
    if (err_out !== 1'b1) begin
      n_fail++; $display("FAIL misaligned_err: got %b want 1", err_out);
    end
    issue(1'b0, 32'h10, 32'h0);
    wait_ready(cyc);
    n_checks++;
    if (err_out !== 1'b0) begin
      n_fail++; $display("FAIL aligned_err_clear: got %b want 0", err_out);
    end
    n_checks++;
    if (data_out !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL misaligned_write_dropped: got %h want deadbeef", data_out);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_write_read();
    test_ready_comb();
    test_out_of_range();
    test_reset_abort();
    test_reset_pending();
    test_back_to_back();
`ifdef DATA_RAM_ALIGN_CHECK_EN
    test_align_check();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_data_ram
